// File: rtl/debounce_pkg.sv
// -----------------------------------------------------------------------------
// debounce_pkg
//
// Shared definitions for the debouncer.
//   state_t      : 2-bit stability FSM state encoding. It lives in a package
//                  so that benches and neighbouring blocks can decode it.
//   state_is_high: helper giving the debounced level held in a given state.
//   state_is_maybe: helper saying whether a state is still qualifying a
//                  candidate transition.
// -----------------------------------------------------------------------------
package debounce_pkg;

    typedef enum logic [1:0] {
        S_LOW        = 2'd0,
        S_MAYBE_HIGH = 2'd1,
        S_HIGH       = 2'd2,
        S_MAYBE_LOW  = 2'd3
    } state_t;

    // While qualifying a fall the output still shows the old (high) level,
    // so S_MAYBE_LOW counts as high.
    function automatic logic state_is_high(input state_t s);
        return (s == S_HIGH) || (s == S_MAYBE_LOW);
    endfunction

    function automatic logic state_is_maybe(input state_t s);
        return (s == S_MAYBE_HIGH) || (s == S_MAYBE_LOW);
    endfunction

endpackage

// File: rtl/debouncer_synchronizer.sv
// -----------------------------------------------------------------------------
// synchronizer
//
// Multi-flop shift-chain synchronizer for one asynchronous single-bit input.
// Reusable for any asynchronous input.
//
// Parameters:
//   STAGES : number of flops in the chain (2 or more).
// Ports:
//   clk : clock
//   rst : synchronous active-high reset, clears every flop to 0
//   in  : asynchronous input
//   out : synchronized input (last flop of the chain)
// -----------------------------------------------------------------------------
module synchronizer #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic out
);

    if (STAGES < 2) begin : g_bad_stages
        $error("synchronizer: STAGES must be 2 or more");
    end

    logic [STAGES-1:0] sync_p;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p <= '0;
        end else begin
            sync_p <= {sync_p[STAGES-2:0], in};
        end
    end

    assign out = sync_p[STAGES-1];

endmodule

// File: rtl/debouncer.sv
// -----------------------------------------------------------------------------
// debouncer
//
// Turns one raw, asynchronous, bouncy input into a glitch-free level in the
// clk domain. The input is synchronized, then a four-state stability FSM
// requires the synchronized value to hold for BOUNCE_TICKS more cycles before
// the output follows. Any disagreement during qualification drops back to the
// previous stable state and the count restarts from zero next time.
//
// Parameters:
//   SYNC_STAGES  : synchronizer depth (2 or more)
//   BOUNCE_TICKS : extra cycles the synchronized input must hold (1 or more)
// Ports:
//   clk      : clock
//   rst      : synchronous active-high reset
//   in       : raw asynchronous input
//   out      : debounced level (registered, no combinational path from in)
//   bouncing : high while a candidate transition is being qualified
// -----------------------------------------------------------------------------
module debouncer
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int BOUNCE_TICKS = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic out,
    output logic bouncing
);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("debouncer: SYNC_STAGES must be 2 or more");
    end
    if (BOUNCE_TICKS < 1) begin : g_bad_ticks
        $error("debouncer: BOUNCE_TICKS must be 1 or more");
    end

    localparam int               CNT_W    = $clog2(BOUNCE_TICKS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BOUNCE_TICKS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             synced;
    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    // ---- stage 0: input synchronization ----
    synchronizer #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .in  (in),
        .out (synced)
    );

    // ---- stage 1: stability FSM and hold counter ----
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_LOW;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // cnt only advances while below CNT_LAST, so it can never wrap.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_LOW: begin
                if (synced) begin
                    state_nxt = S_MAYBE_HIGH;
                    cnt_nxt   = '0;
                end
            end
            S_MAYBE_HIGH: begin
                if (!synced) begin
                    state_nxt = S_LOW;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = S_HIGH;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            S_HIGH: begin
                if (!synced) begin
                    state_nxt = S_MAYBE_LOW;
                    cnt_nxt   = '0;
                end
            end
            S_MAYBE_LOW: begin
                if (synced) begin
                    state_nxt = S_HIGH;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = S_LOW;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nxt = S_LOW;
                cnt_nxt   = '0;
            end
        endcase
    end

    // ---- outputs: Moore, decoded from the registered state only ----
    assign out      = state_is_high(state);
    assign bouncing = state_is_maybe(state);

endmodule

// File: tb/tb_debouncer.sv
// -----------------------------------------------------------------------------
// tb_debouncer
//
// Directed bench for debouncer with default parameters (SYNC_STAGES=2,
// BOUNCE_TICKS=4). A table of per-cycle {rst, in, expected out, expected
// bouncing} records covers reset and clean rise/fall; hand-written sequences
// cover glitches, a bounce train, the qualification-length boundary and
// reset during qualification. Downstream edge detection is modelled here.
// -----------------------------------------------------------------------------
module tb_debouncer;
    import debounce_pkg::*;

    typedef struct packed {
        logic rst;
        logic in;
        logic exp_out;
        logic exp_bnc;
    } vec_t;

    logic clk;
    logic rst;
    logic in;
    logic out;
    logic bouncing;

    int   checks;
    int   errors;
    int   edge_cnt;
    logic out_d;
    vec_t vecs[$];

    debouncer #(
        .SYNC_STAGES  (2),
        .BOUNCE_TICKS (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in       (in),
        .out      (out),
        .bouncing (bouncing)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running required finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    // Apply inputs, let one edge sample them, then look #1 later.
    // Also acts as the downstream edge detector: counts 0->1 of out.
    task automatic step(input logic r, input logic i);
        rst = r;
        in  = i;
        @(posedge clk);
        #1;
        if (out === 1'b1 && out_d === 1'b0) edge_cnt++;
        out_d = out;
    endtask

    task automatic add(input logic r, input logic i, input logic eo, input logic eb);
        vec_t v;
        v.rst = r; v.in = i; v.exp_out = eo; v.exp_bnc = eb;
        vecs.push_back(v);
    endtask

    // Hold in=lvl for n edges starting from the opposite stable level.
    // Edge k=0 is the first sampling edge: bouncing for k=2..5, out flips at k=6.
    task automatic add_qual(input logic lvl, input int n);
        for (int k = 0; k < n; k++) begin
            add(1'b0, lvl, (k >= 6) ? lvl : ~lvl, (k >= 2 && k <= 5));
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        edge_cnt = 0;
        out_d    = 1'b0;
        rst      = 1'b1;
        in       = 1'b0;

        // Reset held 3 cycles with in=1, then release: full qualification path.
        add(1'b1, 1'b1, 1'b0, 1'b0);
        add(1'b1, 1'b1, 1'b0, 1'b0);
        add(1'b1, 1'b1, 1'b0, 1'b0);
        add_qual(1'b1, 20);
        add_qual(1'b0, 10);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].in);
            check($sformatf("vec%0d_out", i), {1'b0, out}, {1'b0, vecs[i].exp_out});
            check($sformatf("vec%0d_bouncing", i), {1'b0, bouncing}, {1'b0, vecs[i].exp_bnc});
        end
        check("table_rise_count", edge_cnt[1:0], 2'd1);

        // Glitch of 3 sampling edges: rejected, bouncing pulses, ends in S_LOW.
        begin
            int bnc_seen;
            bnc_seen = 0;
            for (int k = 0; k < 3; k++) begin
                step(1'b0, 1'b1);
                check("glitch3_out_hi", {1'b0, out}, 2'b00);
                if (bouncing) bnc_seen++;
            end
            for (int k = 0; k < 6; k++) begin
                step(1'b0, 1'b0);
                check("glitch3_out_lo", {1'b0, out}, 2'b00);
                if (bouncing) bnc_seen++;
            end
            check("glitch3_bounced", {1'b0, (bnc_seen > 0)}, 2'b01);
            check("glitch3_bouncing_end", {1'b0, bouncing}, 2'b00);
            check("glitch3_state", dut.state, S_LOW);
        end

        // Boundary: a 4-edge pulse (= BOUNCE_TICKS) is still rejected.
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b1);
            check("pulse4_out_hi", {1'b0, out}, 2'b00);
        end
        for (int k = 0; k < 6; k++) begin
            step(1'b0, 1'b0);
            check("pulse4_out_lo", {1'b0, out}, 2'b00);
        end
        check("pulse4_state", dut.state, S_LOW);

        // Bounce train 1,0,1,0,1 then hold 1: one rise, 6 edges after final 1.
        edge_cnt = 0;
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);                          // edge s
        for (int k = 1; k <= 5; k++) begin
            step(1'b0, 1'b1);
            check("train_out_early", {1'b0, out}, 2'b00);
        end
        step(1'b0, 1'b1);                          // edge s+6
        check("train_out_s6", {1'b0, out}, 2'b01);
        check("train_bouncing_s6", {1'b0, bouncing}, 2'b00);
        for (int k = 0; k < 5; k++) step(1'b0, 1'b1);
        check("train_single_edge", edge_cnt[1:0], 2'd1);

        // Reset mid-qualification in S_MAYBE_LOW.
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check("maybe_low_out", {1'b0, out}, 2'b01);
        check("maybe_low_bouncing", {1'b0, bouncing}, 2'b01);
        check("maybe_low_state", dut.state, S_MAYBE_LOW);
        step(1'b1, 1'b0);
        check("rst_mid_out", {1'b0, out}, 2'b00);
        check("rst_mid_bouncing", {1'b0, bouncing}, 2'b00);
        check("rst_mid_state", dut.state, S_LOW);
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 1'b0);
            check("after_rst_low", {1'b0, out}, 2'b00);
        end

        // Reset while in S_HIGH, then held-high input re-qualifies from scratch.
        for (int k = 0; k < 8; k++) step(1'b0, 1'b1);
        check("pre_rst_high_state", dut.state, S_HIGH);
        step(1'b1, 1'b1);
        check("rst_high_out", {1'b0, out}, 2'b00);
        check("rst_high_state", dut.state, S_LOW);
        for (int k = 0; k <= 5; k++) begin
            step(1'b0, 1'b1);
            check("rst_high_requal_early", {1'b0, out}, 2'b00);
        end
        step(1'b0, 1'b1);
        check("rst_high_requal_s6", {1'b0, out}, 2'b01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/debouncer.md
# debouncer

- Cleans one raw, asynchronous, bouncy input into a single-clock, glitch-free level.
- Feeds the edge detector directly, so a noisy input never produces more than one edge pulse per genuine transition.
- Internally: an N-flop synchronizer, then a four-state stability FSM with a hold counter.
- The output changes only after the synchronized input has held a new value for a programmable number of cycles.

## Interface

Parameters:
- SYNC_STAGES, default 2: synchronizer depth. Legal values are 2 or more.
- BOUNCE_TICKS, default 4: consecutive additional cycles the synchronized input must hold before the output follows. Legal values are 1 or more.

Ports:
- clk  input  1  the single clock.
- rst  input  1  synchronous, active-high reset.
- in  input  1  raw asynchronous input (button or switch).
- out  output  1  debounced level.
- bouncing  output  1  high while a candidate transition is being qualified.

## Operation

- Synchronizer:
  - Shift chain of SYNC_STAGES flops, reset to 0.
  - `synced` is the last stage.
- Hold counter:
  - `cnt` is $clog2(BOUNCE_TICKS+1) bits wide and unsigned.
  - It never wraps.
- FSM states and transitions (next state on each clk edge, rst=0):
  - S_LOW: synced=1 → S_MAYBE_HIGH and cnt←0; otherwise stay.
  - S_MAYBE_HIGH:
    - synced=0 → S_LOW (glitch rejected).
    - synced=1 and cnt==BOUNCE_TICKS-1 → S_HIGH.
    - Otherwise cnt←cnt+1.
  - S_HIGH: synced=0 → S_MAYBE_LOW and cnt←0; otherwise stay.
  - S_MAYBE_LOW:
    - synced=1 → S_HIGH (glitch rejected).
    - synced=0 and cnt==BOUNCE_TICKS-1 → S_LOW.
    - Otherwise cnt←cnt+1.
- Moore outputs (functions of state only):
  - out = (state==S_HIGH) || (state==S_MAYBE_LOW).
  - bouncing = (state==S_MAYBE_HIGH) || (state==S_MAYBE_LOW).
- Glitch handling:
  - A rejected glitch leaves out unchanged.
  - Re-entering a MAYBE state always restarts cnt at 0; there is no partial credit.
- Unreachable state encodings go to S_LOW.

## Timing

- Reset values: all synchronizer flops 0, state S_LOW, cnt 0, out 0, bouncing 0.
- Reset applied mid-qualification, or while in S_HIGH, forces these values at the next edge.
- After rst deasserts, a held-high in takes the full qualification path; there is no shortcut.
- Synchronizer latency:
  - Let the first edge that samples a stable new value of in be edge s.
  - synced changes after edge s+SYNC_STAGES-1.
- Qualification:
  - The FSM leaves the stable state after edge s+SYNC_STAGES (bouncing rises).
  - out changes after edge s+SYNC_STAGES+BOUNCE_TICKS.
  - bouncing falls at that same edge.
- Total latency is SYNC_STAGES+BOUNCE_TICKS+1 edges. With defaults, out changes after edge s+6.
- Pulses on in that are too short never reach out:
  - A pulse spanning at most BOUNCE_TICKS sampling edges is rejected.
  - The exception is a pulse that straddles an already-qualifying transition.
- Rising and falling qualification are symmetric: identical latency and identical rules.
- There is no combinational path from in to any output.

## Structure

- debounce_pkg holds the state enum: 2-bit, S_LOW, S_MAYBE_HIGH, S_HIGH, S_MAYBE_LOW.
  - Kept in a shared package so benches can decode state.
- Natural sub-module: synchronizer (parameter STAGES, ports clk, rst, in, out).
  - Reusable for every asynchronous input in the design.
- debouncer instantiates synchronizer, then the FSM, counter and output logic.
- Elaboration-time checks: SYNC_STAGES≥2 and BOUNCE_TICKS≥1; otherwise $error.

## Test plan

All scenarios use defaults (SYNC_STAGES=2, BOUNCE_TICKS=4).

1. Reset: hold rst=1 for 3 cycles with in=1 → out=0 and bouncing=0 throughout; after release, out rises exactly 6 edges after the first edge with rst=0.
2. Clean rise and fall: in 0→1, held 20 cycles, then 1→0 → out rises after edge s+6 and falls 6 edges after the falling sample; bouncing is high for exactly 4 cycles each time.
3. Glitch rejection: in=1 for 3 sampling edges, then 0 → out stays 0; bouncing pulses, then returns to 0; state ends in S_LOW.
4. Bounce train: in toggles 1,0,1,0,1 on consecutive cycles, then holds 1 → out rises exactly 6 edges after the final 0→1 sample, with a single rising transition.
5. Reset mid-qualification: assert rst while bouncing=1 in S_MAYBE_LOW (out=1) → out=0, bouncing=0, state S_LOW at the next edge.
6. Chained with the edge detector: the bounce train from scenario 4 → exactly one positive_edge pulse downstream.
